alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, registered, multicycle successor to the 32-bit combinational ALU.
- Performs the same eight logic/arithmetic opcodes plus a sequential unsigned multiply.
- Adds a start/busy/done handshake, a registered 2*WIDTH result, and N/Z/C/V and error flags.
- Sits between the operand registers and the result/flag register stage of the datapath.

Parameters:
- WIDTH, 32, operand width in bits (≥4); result is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- op  input  4  opcode, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result and flags valid from this cycle
- result  output  2*WIDTH  registered result; holds until the next done
- flag_n  output  1  negative flag
- flag_z  output  1  zero flag
- flag_c  output  1  carry flag
- flag_v  output  1  signed-overflow flag
- err  output  1  illegal opcode; updated with done

Behaviour:
- Reset (async, active-high): state=IDLE; busy, done, result, all flags and err = 0. Reset asserted mid-operation aborts the operation; no done is produced.
- Opcodes:
  - 0000 NOP, result 0
  - 0001 NOT_A
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 XNOR
  - 0110 ADD
  - 0111 SUB (a + ~b + 1)
  - 1000 MUL (unsigned a*b)
  - 1001-1111 illegal
- FSM states:
  - IDLE: start=1 → latch op/a/b. Non-MUL ops go to EXEC; MUL goes to MUL.
  - EXEC: compute and register result/flags; done=1; go to IDLE. Latency: done is 1 cycle after the accepted start.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, WIDTH iterations with a counter 0..WIDTH-1. After the last iteration, register result/flags, done=1, go to IDLE. Latency: done is WIDTH+1 cycles after start (33 at default). busy=1 throughout.
- start while busy=1 is ignored, with no queueing. start in the same cycle as done (busy=0 in IDLE next) is accepted in the following IDLE cycle only. done and a new busy never overlap.
- Width rules:
  - Non-MUL ops: result[2W-1:W] = 0.
  - ADD/SUB: computed at W+1 bits.
  - flag_z: asserted when the full 2W-bit result == 0.
  - flag_n: result[W-1] for non-MUL ops; result[2W-1] for MUL.
  - flag_c: carry-out for ADD; carry-out of a+~b+1 for SUB (1 = no borrow); 0 otherwise.
  - flag_v: signed overflow for ADD/SUB; 0 otherwise.
- Illegal opcode: follows the EXEC timing; result=0, all flags 0, err=1. For every legal op, err=0.
- NOP: done still pulses; flag_z=1.
- Outputs hold their values between done pulses.

Optional Feature:
- Macro: ALU_MC_MUL_EN.
- Defined: the MUL state, multiplier datapath and counter are present; opcode 1000 behaves as specified above.
- Undefined: no multiplier logic is built; opcode 1000 is treated as illegal (EXEC timing, err=1, result 0). busy is never longer than one cycle.

Decomposition:
- Shared package alu_pkg:
  - opcode constants (OP_NOP … OP_MUL)
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_MUL)
  - flag index constants
- Sub-module alu_mul_seq: shift-add multiplier core with load/step/last handshake and a WIDTH-bit counter. It is instantiated only under ALU_MC_MUL_EN.
- The adder is a behavioural W+1-bit add; the existing cla32 may be reused when WIDTH=32.

Test Plan:
- ADD a=0xFFFFFFFF b=0x00000001 → done 1 cycle after start; result=0, z=1, c=1, v=0, n=0.
- SUB a=0x80000000 b=0x00000001 → result=0x000000007FFFFFFF, v=1, c=1, n=0, z=0.
- XNOR a=0xF0F0F0F0 b=0xFF00FF00 → result=0x00000000F00FF00F, c=v=0; upper half 0.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF, with a second start pulsed at cycle 5 → single done at cycle 33; result=0xFFFFFFFE00000001, n=1; the second start is ignored.
- Reset asserted at cycle 10 of a MUL → busy/done/result/flags immediately 0, no done. A following ADD 3+4 → result=7 after 1 cycle.
- op=4'b1111 → err=1, result=0, flags 0. Without ALU_MC_MUL_EN, op=4'b1000 → err=1 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_NOT_A = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_XNOR  = 4'b0101;
  localparam logic [3:0] OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10
  } state_t;

  localparam int FLAG_N    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

  // Two's-complement overflow of x + y from the sign bits of the addends and the sum.
  function automatic logic add_ovf(input logic x_msb, input logic y_msb, input logic sum_msb);
    return (x_msb == y_msb) && (sum_msb != x_msb);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier core: load latches operands, each step retires one
// multiplier bit; last flags the final step, whose sum is presented on product.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(WIDTH - 1);

  logic [W2-1:0]    acc_r;
  logic [W2-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] cnt_r;
  logic [W2-1:0]    addend_s;

  // Partial product of the current step; product is the accumulator after this step.
  always_comb begin
    addend_s = {W2{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {W2{1'b0}};
    end
  end

  assign product = acc_r + addend_s;
  assign last    = step && (cnt_r == LAST_CNT);

  // Operand shifters, accumulator and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r    <= {W2{1'b0}};
      mcand_r  <= {W2{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {WIDTH{1'b0}};
    end else if (load) begin
      acc_r    <= {W2{1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      cnt_r    <= {WIDTH{1'b0}};
    end else if (step) begin
      acc_r    <= product;
      mcand_r  <= {mcand_r[W2-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multicycle ALU with start/busy/done handshake and N/Z/C/V/err flags.
// Optional sequential multiplier enabled by defining ALU_MC_MUL_EN.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 err
);

  localparam int W2 = 2 * WIDTH;

  state_t                 state_r, state_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   err_r, err_nxt_s;
  logic [W2-1:0]          result_r, result_nxt_s;
  logic [NUM_FLAGS-1:0]   flags_r, flags_nxt_s;
  logic                   upd_s;

  logic                   accept_s;
  logic                   is_mul_s;
  logic                   mul_load_s;
  logic                   mul_step_s;
  logic                   mul_last_s;
  logic [W2-1:0]          mul_prod_s;

  logic [WIDTH:0]         sum_s;
  logic [WIDTH:0]         diff_s;
  logic [WIDTH-1:0]       low_s;
  logic                   c_s, v_s, alu_err_s;
  logic [NUM_FLAGS-1:0]   alu_flags_s;

  assign accept_s   = start && !busy_r && (state_r == ST_IDLE);
  assign mul_step_s = (state_r == ST_MUL);

`ifdef ALU_MC_MUL_EN
  assign is_mul_s = (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load_s),
    .step    (mul_step_s),
    .a       (a),
    .b       (b),
    .last    (mul_last_s),
    .product (mul_prod_s)
  );
`else
  assign is_mul_s   = 1'b0;
  assign mul_last_s = 1'b0;
  assign mul_prod_s = {W2{1'b0}};
`endif

  // Single-cycle ops evaluate straight from the input operands so their result can be
  // registered on the accepting edge; OP_MUL falls into the illegal arm here and is only
  // routed to the multiplier when it is built.
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b};
    diff_s    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    low_s     = {WIDTH{1'b0}};
    c_s       = 1'b0;
    v_s       = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      OP_NOP:   low_s = {WIDTH{1'b0}};
      OP_NOT_A: low_s = ~a;
      OP_AND:   low_s = a & b;
      OP_OR:    low_s = a | b;
      OP_XOR:   low_s = a ^ b;
      OP_XNOR:  low_s = ~(a ^ b);
      OP_ADD: begin
        low_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        low_s = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        v_s   = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff_s[WIDTH-1]);
      end
      default:  alu_err_s = 1'b1;
    endcase
    alu_flags_s = {NUM_FLAGS{1'b0}};
    if (!alu_err_s) begin
      alu_flags_s[FLAG_N] = low_s[WIDTH-1];
      alu_flags_s[FLAG_Z] = (low_s == {WIDTH{1'b0}});
      alu_flags_s[FLAG_C] = c_s;
      alu_flags_s[FLAG_V] = v_s;
    end else begin
      alu_flags_s = {NUM_FLAGS{1'b0}};
    end
  end

  // Next-state and next-output logic; busy stays high through the done cycle so a start
  // coinciding with done is dropped rather than queued.
  always_comb begin
    state_nxt_s  = state_r;
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    mul_load_s   = 1'b0;
    upd_s        = 1'b0;
    result_nxt_s = {{WIDTH{1'b0}}, low_s};
    flags_nxt_s  = alu_flags_s;
    err_nxt_s    = alu_err_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_nxt_s = ST_MUL;
          busy_nxt_s  = 1'b1;
          mul_load_s  = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = ST_EXEC;
          busy_nxt_s  = 1'b1;
          done_nxt_s  = 1'b1;
          upd_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_IDLE;
      end
      ST_MUL: begin
        busy_nxt_s = 1'b1;
        if (mul_last_s) begin
          state_nxt_s         = ST_IDLE;
          done_nxt_s          = 1'b1;
          upd_s               = 1'b1;
          result_nxt_s        = mul_prod_s;
          err_nxt_s           = 1'b0;
          flags_nxt_s         = {NUM_FLAGS{1'b0}};
          flags_nxt_s[FLAG_N] = mul_prod_s[W2-1];
          flags_nxt_s[FLAG_Z] = (mul_prod_s == {W2{1'b0}});
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake, result and flag registers; result/flags/err hold between done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {W2{1'b0}};
      flags_r  <= {NUM_FLAGS{1'b0}};
      err_r    <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (upd_s) begin
        result_r <= result_nxt_s;
        flags_r  <= flags_nxt_s;
        err_r    <= err_nxt_s;
      end else begin
        result_r <= result_r;
        flags_r  <= flags_r;
        err_r    <= err_r;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign flag_n = flags_r[FLAG_N];
  assign flag_z = flags_r[FLAG_Z];
  assign flag_c = flags_r[FLAG_C];
  assign flag_v = flags_r[FLAG_V];
  assign err    = err_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against an
// arithmetic reference model. Multiply checks follow ALU_MC_MUL_EN.
module tb_alu_mc;

  localparam int W = 32;

`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [3:0]     op;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic           flag_n, flag_z, flag_c, flag_v, err;

  int             checks = 0;
  int             errors = 0;
  logic [63:0]    got_res;

  alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_v (flag_v),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] r, output logic [3:0] nzcv, output logic e);
    longint sd;
    logic   n, z, c, v;
    r = 64'd0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      4'd0: r = 64'd0;
      4'd1: r = {32'd0, ~x};
      4'd2: r = {32'd0, x & y};
      4'd3: r = {32'd0, x | y};
      4'd4: r = {32'd0, x ^ y};
      4'd5: r = {32'd0, ~(x ^ y)};
      4'd6: begin
        r  = ({32'd0, x} + {32'd0, y}) & 64'h0000_0000_FFFF_FFFF;
        c  = ({32'd0, x} + {32'd0, y}) > 64'h0000_0000_FFFF_FFFF;
        sd = longint'($signed(x)) + longint'($signed(y));
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      4'd7: begin
        r  = ({32'd0, x} - {32'd0, y}) & 64'h0000_0000_FFFF_FFFF;
        c  = (x >= y);
        sd = longint'($signed(x)) - longint'($signed(y));
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      4'd8: begin
        if (MUL_EN) r = {32'd0, x} * {32'd0, y};
        else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    n = (MUL_EN && o == 4'd8) ? r[63] : r[31];
    z = (r == 64'd0);
    nzcv = e ? 4'b0000 : {n, z, c, v};
  endfunction

  // One complete transaction: latency, result, flags, err, done pulse width, hold.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] er;
    logic [3:0]  ef;
    logic        ee;
    int          lat, cyc;
    model(o, x, y, er, ef, ee);
    lat = (MUL_EN && o == 4'd8) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    chk({tag, "_busy1"}, 64'(busy), 64'd1);
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    got_res = result;
    chk({tag, "_res"}, result, er);
    chk({tag, "_nzcv"}, 64'({flag_n, flag_z, flag_c, flag_v}), 64'(ef));
    chk({tag, "_err"}, 64'(err), 64'(ee));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, result, er);
  endtask

  initial begin
    logic [31:0] edge_v [6];
    logic [3:0]  ro;
    logic [31:0] rx, ry;
    int          dones, first_done;

    edge_v[0] = 32'h0000_0000; edge_v[1] = 32'hFFFF_FFFF; edge_v[2] = 32'h8000_0000;
    edge_v[3] = 32'h7FFF_FFFF; edge_v[4] = 32'h0000_0001; edge_v[5] = 32'hAAAA_5555;

    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'({flag_n, flag_z, flag_c, flag_v, err}), 64'd0);
    reset = 1'b0;

    do_op("add_wrap", 4'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("tp_add_z", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0110);
    do_op("sub_ovf", 4'd7, 32'h8000_0000, 32'h0000_0001);
    chk("tp_sub_res", got_res, 64'h0000_0000_7FFF_FFFF);
    do_op("xnor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("tp_xnor_res", got_res, 64'h0000_0000_F00F_F00F);
    do_op("nop", 4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op("illegal_f", 4'd15, 32'hDEAD_BEEF, 32'h1);
    do_op("op_mul", 4'd8, 32'h0001_0003, 32'h0002_0005);
    do_op("not_a", 4'd1, 32'h0F0F_0000, 32'h0);

    // start pulsed only while done/busy are high must not be queued
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 32'd1; b = 32'd2;
    @(negedge clk);
    op = 4'd4; a = 32'hFFFF_0000; b = 32'h0;
    chk("ign_done", 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("ign_no_done", 64'(dones), 64'd0);
    chk("ign_result", result, 64'd3);

    // async reset while an operation's done is showing
    @(negedge clk);
    start = 1'b1; op = 4'd6; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("after_rst_add", 4'd6, 32'd3, 32'd4);
    chk("after_rst_7", got_res, 64'd7);

`ifdef ALU_MC_MUL_EN
    // MUL with a second start at cycle 5: exactly one done at cycle 33
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    dones = 0; first_done = 0;
    for (int cyc = 1; cyc < 45; cyc++) begin
      if (cyc == 5) begin start = 1'b1; op = 4'd6; a = 32'd1; b = 32'd1; end
      if (cyc == 6) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first_done == 0) begin
          first_done = cyc;
          chk("mul_res", result, 64'hFFFF_FFFE_0000_0001);
          chk("mul_n", 64'(flag_n), 64'd1);
        end
      end
      @(negedge clk);
    end
    chk("mul_dones", 64'(dones), 64'd1);
    chk("mul_lat", 64'(first_done), 64'd33);

    // reset at cycle 10 of a MUL aborts it
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("mrst_no_done", 64'(dones), 64'd0);
    do_op("mrst_add", 4'd6, 32'd3, 32'd4);
    chk("mrst_add_7", got_res, 64'd7);
`else
    dones = 0; first_done = 0;
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : 32'($urandom);
      ry = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : 32'($urandom);
      do_op("rand", ro, rx, ry);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
